// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data memory controller: funct3 encodings,
// controller state encoding and the access-size helper.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bytes touched by an access; funct3 encoding 3 has no legal size and is
    // flagged elsewhere, so its value here only needs to be harmless.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3[1:0])
            2'd0:    size = 3'd1;
            2'd1:    size = 3'd2;
            2'd2:    size = 3'd4;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational access decode: fault detection, big-endian byte-lane write
// enables/data and load extraction with sign/zero extension.
// Lane i (i = 0..3) is the byte at addr+i; it sits in bits [31-8i -: 8] of
// the lane buses and in bit [3-i] of lane_we, so a word maps straight through.
module mem_align_unit
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rword,
    output logic              err,
    output logic [3:0]        lane_we,
    output logic [31:0]       lane_wdata,
    output logic [31:0]       rdata
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [2:0]      size_s;
    logic [ADDR_W:0] end_s;
    logic            f3_bad_s;
    logic            misalign_s;
    logic            range_bad_s;
    logic [31:0]     load_s;

    // Fault detection; the end address carries one extra bit so it cannot wrap.
    always_comb begin
        size_s = access_size(funct3);
        end_s  = {1'b0, addr} + (ADDR_W+1)'(size_s);
        if (we) begin
            f3_bad_s = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        end else begin
            f3_bad_s = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        case (funct3[1:0])
            2'd1:    misalign_s = addr[0];
            2'd2:    misalign_s = (addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        range_bad_s = (end_s > DEPTH_X);
        err         = f3_bad_s || misalign_s || range_bad_s;
    end

    // Store lane steering: the most significant store byte lands at addr.
    always_comb begin
        case (funct3[1:0])
            2'd0: begin
                lane_we    = 4'b1000;
                lane_wdata = {wdata[7:0], 24'h00_0000};
            end
            2'd1: begin
                lane_we    = 4'b1100;
                lane_wdata = {wdata[15:0], 16'h0000};
            end
            default: begin
                lane_we    = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
        if (!we || err) begin
            lane_we = 4'b0000;
        end else begin
            lane_we = lane_we;
        end
    end

    // Load extraction; funct3[2] selects zero extension.
    always_comb begin
        case (funct3[1:0])
            2'd0: begin
                if (funct3[2]) begin
                    load_s = {24'h00_0000, rword[31:24]};
                end else begin
                    load_s = {{24{rword[31]}}, rword[31:24]};
                end
            end
            2'd1: begin
                if (funct3[2]) begin
                    load_s = {16'h0000, rword[31:16]};
                end else begin
                    load_s = {{16{rword[31]}}, rword[31:16]};
                end
            end
            default: load_s = rword;
        endcase
        if (we || err) begin
            rdata = 32'h0000_0000;
        end else begin
            rdata = load_s;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with a valid/ready request/response
// handshake and a configurable number of wait states before each response.
module data_mem_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES);
    localparam state_e     ACCEPT_NXT = (WAIT_CYCLES > 0) ? BUSY : RESP;

    logic [7:0]        mem_r [DEPTH];
    state_e            state_r;
    state_e            state_nxt_s;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;

    logic              accept_s;
    logic              commit_s;
    logic              dec_we_s;
    logic [2:0]        dec_funct3_s;
    logic [ADDR_W-1:0] dec_addr_s;
    logic [31:0]       dec_wdata_s;
    logic [IDX_W-1:0]  idx0_s, idx1_s, idx2_s, idx3_s;
    logic [31:0]       rword_s;
    logic              err_s;
    logic [3:0]        lane_we_s;
    logic [31:0]       lane_wdata_s;
    logic [31:0]       rdata_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    assign accept_s = (state_r == IDLE) && req_valid;
    assign commit_s = (state_nxt_s == RESP) && (state_r != RESP);

    // Decode operands: with zero wait states the commit edge is the accept
    // edge, so the request fields are decoded before they are latched.
    always_comb begin
        if (state_r == IDLE) begin
            dec_we_s     = req_we;
            dec_funct3_s = req_funct3;
            dec_addr_s   = req_addr;
            dec_wdata_s  = req_wdata;
        end else begin
            dec_we_s     = we_r;
            dec_funct3_s = funct3_r;
            dec_addr_s   = addr_r;
            dec_wdata_s  = wdata_r;
        end
    end

    // Byte indices for the four lanes; wrap is harmless since any wrapping
    // access is flagged out of range and neither writes nor returns data.
    always_comb begin
        idx0_s  = dec_addr_s[IDX_W-1:0];
        idx1_s  = idx0_s + IDX_W'(1);
        idx2_s  = idx0_s + IDX_W'(2);
        idx3_s  = idx0_s + IDX_W'(3);
        rword_s = {mem_r[idx0_s], mem_r[idx1_s], mem_r[idx2_s], mem_r[idx3_s]};
    end

    mem_align_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_align (
        .we         (dec_we_s),
        .funct3     (dec_funct3_s),
        .addr       (dec_addr_s),
        .wdata      (dec_wdata_s),
        .rword      (rword_s),
        .err        (err_s),
        .lane_we    (lane_we_s),
        .lane_wdata (lane_wdata_s),
        .rdata      (rdata_s)
    );

    // Next-state logic for the IDLE -> (BUSY) -> RESP handshake sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ACCEPT_NXT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == WAIT_LAST) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, wait counter, request latch and registered response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
            end
            if (accept_s && (state_nxt_s == BUSY)) begin
                cnt_r <= 4'd1;
            end else if (state_r == BUSY) begin
                cnt_r <= (state_nxt_s == RESP) ? 4'd0 : cnt_r + 4'd1;
            end
            if (commit_s) begin
                rsp_rdata_r <= rdata_s;
                rsp_err_r   <= err_s;
            end
        end
    end

    // Store commit on the edge entering RESP; lanes are already gated off on
    // faults, and a reset on that edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (commit_s && !RST) begin
            if (lane_we_s[3]) mem_r[idx0_s] <= lane_wdata_s[31:24];
            if (lane_we_s[2]) mem_r[idx1_s] <= lane_wdata_s[23:16];
            if (lane_we_s[1]) mem_r[idx2_s] <= lane_wdata_s[15:8];
            if (lane_we_s[0]) mem_r[idx3_s] <= lane_wdata_s[7:0];
        end
    end

endmodule
